// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. A parallel pattern of 1..W bits is accepted
// through a valid/ready handshake and sent MSB-first on x, one bit per
// enabled cycle. Each frame is followed by GAP zero guard bits so the
// three-1s detector on the far end drops back to idle between frames.
module seq_pattern_tx #(
  parameter int W   = 8,
  parameter int LW  = 4,
  parameter int GAP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  din,
  input  logic [LW-1:0] len,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          en,
  output logic          x,
  output logic          x_valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;

  // W expressed in the len field width; 2^LW > W guarantees it fits.
  localparam logic [LW-1:0] W_L = LW'(W);
  // Guard counter value on the last guard bit (unused when GAP = 0).
  localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

  logic [1:0]    state;
  logic [W-1:0]  sreg;   // pattern left-aligned so sreg[W-1] is the next bit
  logic [LW-1:0] cnt;    // frame bits still to send
  logic [3:0]    gcnt;   // guard bits already sent
  logic          len_ok;

  // Legal frame lengths are 1..W; anything else is rejected with err.
  assign len_ok = (len != '0) && (len <= W_L);

  // Handshake and status decode directly from the state register.
  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Frame sequencer: load, shift out MSB-first, then emit guard zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          x       <= 1'b0;
          x_valid <= 1'b0;
          if (load_valid) begin
            if (len_ok) begin
              // Shift din[len-1] up to the MSB; bits above it fall off.
              sreg  <= din << (W_L - len);
              cnt   <= len;
              state <= SHIFT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (en) begin
            x       <= sreg[W-1];
            x_valid <= 1'b1;
            sreg    <= sreg << 1;
            cnt     <= cnt - LW'(1);
            if (cnt == LW'(1)) begin
              done  <= 1'b1;
              state <= (GAP > 0) ? GUARD : IDLE;
            end
          end else begin
            // x keeps the last bit while the line is stalled.
            x_valid <= 1'b0;
          end
        end
        GUARD: begin
          x       <= 1'b0;
          x_valid <= en;
          if (en) begin
            if (gcnt == GAP_LAST) begin
              gcnt  <= '0;
              state <= IDLE;
            end else begin
              gcnt <= gcnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx. Two instances share all inputs, one
// with a single guard bit and one with two, so each frame checks both guard
// lengths. Per-cycle expectations are hand-written bit masks where bit i is
// the value seen just after edge k+i (k = accept edge).
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [3:0] len;
  logic       load_valid;
  logic       en;

  logic x1, xv1, busy1, done1, err1, rdy1;
  logic x2, xv2, busy2, done2, err2, rdy2;

  int checks   = 0;
  int failures = 0;
  int run      = 0;
  int ycount   = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.W(8), .LW(4), .GAP(1)) u_g1 (
    .clk(clk), .rst(rst), .din(din), .len(len), .load_valid(load_valid),
    .load_ready(rdy1), .en(en), .x(x1), .x_valid(xv1), .busy(busy1),
    .done(done1), .err(err1)
  );

  seq_pattern_tx #(.W(8), .LW(4), .GAP(2)) u_g2 (
    .clk(clk), .rst(rst), .din(din), .len(len), .load_valid(load_valid),
    .load_ready(rdy2), .en(en), .x(x2), .x_valid(xv2), .busy(busy2),
    .done(done2), .err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference three-1s detector fed from the GAP=1 instance.
  task automatic detect();
    if (xv1) begin
      run = x1 ? run + 1 : 0;
      if (x1 && run >= 3) ycount++;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle1"}, {28'd0, x1, xv1, rdy1, busy1}, 32'h2);
    check({tag, " idle2"}, {28'd0, x2, xv2, rdy2, busy2}, 32'h2);
  endtask

  // Load one frame, then check n cycles against the expected masks. A
  // stray load_valid mid-frame and changes to din/len after acceptance
  // must have no effect.
  task automatic run_chk(input string name, input logic [7:0] d, input logic [3:0] l,
                         input int n, input logic [31:0] enp, input logic [31:0] ex,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic [31:0] dn, input logic [31:0] r1,
                         input logic [31:0] r2);
    run    = 0;
    ycount = 0;
    din = d; len = l; load_valid = 1'b1; en = 1'b1;
    tick();
    load_valid = 1'b0; din = ~d; len = 4'd5;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        en = enp[i];
        if (i == 2) begin
          load_valid = 1'b1;
          len = 4'd0;
        end
        tick();
        load_valid = 1'b0;
        len = 4'd5;
      end
      detect();
      check($sformatf("%s x1 c%0d", name, i), 32'(x1), 32'(ex[i]));
      check($sformatf("%s x2 c%0d", name, i), 32'(x2), 32'(ex[i]));
      check($sformatf("%s xv1 c%0d", name, i), 32'(xv1), 32'(v1[i]));
      check($sformatf("%s xv2 c%0d", name, i), 32'(xv2), 32'(v2[i]));
      check($sformatf("%s done1 c%0d", name, i), 32'(done1), 32'(dn[i]));
      check($sformatf("%s done2 c%0d", name, i), 32'(done2), 32'(dn[i]));
      check($sformatf("%s rdy1 c%0d", name, i), 32'(rdy1), 32'(r1[i]));
      check($sformatf("%s rdy2 c%0d", name, i), 32'(rdy2), 32'(r2[i]));
      check($sformatf("%s busy1 c%0d", name, i), 32'(busy1), 32'(!r1[i]));
      check($sformatf("%s err c%0d", name, i), {30'd0, err1, err2}, 32'd0);
    end
  endtask

  task automatic bad_load(input string tag, input logic [3:0] l);
    din = 8'hFF; len = l; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check({tag, " err"}, {30'd0, err1, err2}, 32'h3);
    check_idle(tag);
    tick();
    check({tag, " err clear"}, {30'd0, err1, err2}, 32'h0);
    check_idle({tag, " after"});
  endtask

  initial begin
    rst = 1'b1; din = '0; len = '0; load_valid = 1'b0; en = 1'b0;
    #2;
    check_idle("reset");
    check("reset done/err", {28'd0, done1, err1, done2, err2}, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Idle with enable running and no loads.
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle($sformatf("noload c%0d", i));
    end

    // All-ones, full-width frame: detector fires on bits 3..8.
    run_chk("ff", 8'hFF, 4'd8, 12, 32'hFFFF_FFFF, 32'h0000_01FE,
            32'h0000_03FE, 32'h0000_07FE, 32'h0000_0100,
            32'hFFFF_FE00, 32'hFFFF_FC00);
    check("ff y count", 32'(ycount), 32'd6);

    // 1,1,0,1 then guard zeros: detector never fires.
    run_chk("0d", 8'h0D, 4'd4, 10, 32'hFFFF_FFFF, 32'h0000_0016,
            32'h0000_003E, 32'h0000_007E, 32'h0000_0010,
            32'hFFFF_FFE0, 32'hFFFF_FFC0);
    check("0d y count", 32'(ycount), 32'd0);

    // Upper din bits beyond len are ignored: F2 with len 2 sends 1,0.
    run_chk("f2", 8'hF2, 4'd2, 8, 32'hFFFF_FFFF, 32'h0000_0002,
            32'h0000_000E, 32'h0000_001E, 32'h0000_0004,
            32'hFFFF_FFF8, 32'hFFFF_FFF0);

    // Rejected loads.
    bad_load("len0", 4'd0);
    bad_load("len9", 4'd9);
    bad_load("len15", 4'd15);

    // Stalled line: A5 with en 1,0,1,1,0,... stretches the frame.
    run_chk("a5", 8'hA5, 4'd8, 20, 32'h0005_6B5A, 32'h0000_2636,
            32'h0000_6B5A, 32'h0001_6B5A, 32'h0000_2000,
            32'hFFFF_C000, 32'hFFFF_0000);
    check("a5 y count", 32'(ycount), 32'd0);

    // Reset in the middle of a frame clears outputs immediately.
    en = 1'b1; din = 8'hFF; len = 4'd8; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick(); tick(); tick();
    check("mid x", {30'd0, x1, xv1}, 32'h3);
    #2;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    check("midrst done", {30'd0, done1, done2}, 32'h0);
    tick();
    rst = 1'b0;
    check_idle("post rst");

    // Clean frame after reset: 1,1,1 with the detector firing on bit 3.
    run_chk("07", 8'h07, 4'd3, 7, 32'hFFFF_FFFF, 32'h0000_000E,
            32'h0000_001E, 32'h0000_003E, 32'h0000_0008,
            32'hFFFF_FFF0, 32'hFFFF_FFE0);
    check("07 y count", 32'(ycount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
